if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
- Instruction-fetch front end of the 5-stage MIPS32 core.
- Owns the PC register and drives the chip-enable and byte address into the combinational instruction ROM.
- Captures the returned instruction word together with its PC into the IF/ID pipeline register.
- Honours pipeline stalls, taken branches from ID, and flushes from the exception/CP0 logic.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset release.
- PC_STEP, 4, byte increment per sequential fetch; ROM is word-addressed, so the ROM indexes with addr[N+1:2].

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; release is synchronous to clk.
- stall  in  6  pipeline stall vector: bit0 = PC stage, bit1 = IF, bit2 = ID; bits 3-5 are ignored here.
- flush  in  1  exception/eret flush from control.
- new_pc  in  32  redirect target, valid with flush.
- branch_flag_i  in  1  ID resolved a taken branch/jump.
- branch_target_address_i  in  32  target for branch_flag_i.
- rom_inst_i  in  32  instruction word returned combinationally by the ROM.
- rom_ce_o  out  1  ROM chip enable; ROM outputs zero when low.
- rom_addr_o  out  32  byte address (the PC).
- id_pc_o  out  32  IF/ID register: PC of the instruction.
- id_inst_o  out  32  IF/ID register: instruction word.

Behaviour:
- Reset: rom_ce_o=0, rom_addr_o=RESET_PC, id_pc_o=0, id_inst_o=0 (NOP).
- FSM: IDLE -> RUN.
  - IDLE is entered on reset and lasts exactly one clk after rst deasserts; rom_ce_o=0 in IDLE.
  - On that edge the FSM goes to RUN, with rom_ce_o=1 and pc=RESET_PC. It stays in RUN until reset.
  - Reset asserted mid-operation returns the FSM to IDLE immediately (async) and restores all reset values.
- PC update in RUN, priority highest first:
  - flush: pc<=new_pc, regardless of stall.
  - stall[0]: pc held.
  - branch_flag_i: pc<=branch_target_address_i.
  - otherwise: pc<=pc+PC_STEP, wrapping modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
  - In IDLE, pc stays RESET_PC.
- Delay slot: the instruction fetched in the cycle branch_flag_i is seen is the delay slot. It is NOT squashed.
- IF/ID register in RUN, priority highest first:
  - flush: id_pc_o=0, id_inst_o=0.
  - stall[1]=1 and stall[2]=0: insert a bubble (zeros).
  - stall[1]=0: capture rom_addr_o / rom_inst_i.
  - otherwise: hold.
- When rom_ce_o=0, the value captured is 0 (NOP), never stale data.
- Latency: an instruction appears on id_*_o one clk after its PC is on rom_addr_o.
- First instruction: at the first clk after reset release, rom_ce_o=1 and rom_addr_o=RESET_PC. That instruction reaches id_*_o at the second clk.
- Simultaneous flush+branch: flush wins and the branch is discarded. Simultaneous flush+stall: flush wins.

Optional Feature:
- Macro: IF_ADEL_CHECK_EN.
- When defined: if pc[1:0]!=0 in RUN, the block drives rom_ce_o=0 and loads a NOP into IF/ID.
  - Adds output id_excepttype_o (32): bit 4 (AdEL) is set with the NOP. This bit uses the same encoding as the core's other stage exception vectors.
  - The PC still advances normally until control flushes.
- When undefined: no alignment check and no id_excepttype_o port; pc[1:0] is passed through unchanged.

Decomposition:
- Shared defines package carries:
  - `ZeroWord, `InstAddrBus, `InstBus, `Enable/`Disable.
  - Stall-vector bit indices, RESET_PC default, and exception-type bit positions.
  - FSM state encoding (IDLE=1'b0, RUN=1'b1).
- One sub-module is natural: if_id_reg (the IF/ID pipeline register with its flush/bubble/hold logic).
- The PC/FSM logic stays in the top.

Test Plan:
- Reset release, no stalls, ROM holding words W0..W3:
  - rom_ce_o rises one clk after rst goes high.
  - rom_addr_o steps 0,4,8,C.
  - id_inst_o = W0,W1,W2 on successive clks.
- stall=6'b000011 for 2 clks at pc=0x8:
  - rom_addr_o held at 0x8 for 2 clks.
  - id_*_o = 0 during the bubble.
  - Normal flow resumes with W2 next.
- branch_flag_i=1, target 0x40, asserted while pc=0x10:
  - Delay slot at 0x10 is still delivered to ID.
  - Next rom_addr_o = 0x40.
- flush=1, new_pc=0x20, asserted together with branch_flag_i and stall[0]:
  - pc=0x20 next clk.
  - id_*_o = 0.
  - The branch is ignored.
- Wrap test: force pc=0xFFFF_FFFC via flush, no stall -> next pc is 0x0000_0000.
- IF_ADEL_CHECK_EN defined, flush to 0x22:
  - rom_ce_o=0.
  - id_inst_o=0.
  - id_excepttype_o bit4=1 one clk later.
- Async reset asserted mid-stream (between edges):
  - All outputs go to reset values immediately.
  - The FSM restarts in IDLE.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage_pkg
// Description : Shared definitions for the MIPS32 instruction-fetch stage:
//               bus widths, enable levels, stall-vector bit indices, the
//               default reset PC, exception-type bit positions and the
//               fetch FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_stage_pkg;

  // Bus widths and common constants
  localparam int          INST_ADDR_W      = 32;
  localparam int          INST_W           = 32;
  localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
  localparam logic        ENABLE           = 1'b1;
  localparam logic        DISABLE          = 1'b0;

  // Stall vector bit positions (bits 3..5 belong to later stages)
  localparam int          STALL_PC         = 0;
  localparam int          STALL_IF         = 1;
  localparam int          STALL_ID         = 2;

  // Default first fetch address
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Exception-type vector bit positions shared by all stages
  localparam int          EXC_ADEL_BIT     = 4;

  // Fetch FSM
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_e;

endpackage : if_fetch_stage_pkg
`default_nettype wire

// File: rtl/if_fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage_if_id_reg
// Description : IF/ID pipeline register. Priority: flush clears, a stall of
//               IF with ID running inserts a bubble, an unstalled IF
//               captures the fetch, otherwise the register holds.
// Optional    : IF_ADEL_CHECK_EN adds the exception-type field.
// Ports       : clk, rst (async active-low), flush, stall_if, stall_id,
//               if_pc/if_inst (fetch data, already zeroed when ROM disabled),
//               id_pc_o/id_inst_o (registered outputs),
//               if_excepttype/id_excepttype_o (feature only).
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage_if_id_reg
  import if_fetch_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   stall_if,
  input  logic                   stall_id,
  input  logic [INST_ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0]      if_inst,
`ifdef IF_ADEL_CHECK_EN
  input  logic [31:0]            if_excepttype,
  output logic [31:0]            id_excepttype_o,
`endif
  output logic [INST_ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0]      id_inst_o
);

  logic [INST_ADDR_W-1:0] pc_q,   pc_d;
  logic [INST_W-1:0]      inst_q, inst_d;
`ifdef IF_ADEL_CHECK_EN
  logic [31:0]            exc_q,  exc_d;
`endif

  always_comb begin
    pc_d   = pc_q;
    inst_d = inst_q;
`ifdef IF_ADEL_CHECK_EN
    exc_d  = exc_q;
`endif
    if (flush || (stall_if && !stall_id)) begin
      // Flush and bubble both load a NOP
      pc_d   = ZERO_WORD;
      inst_d = ZERO_WORD;
`ifdef IF_ADEL_CHECK_EN
      exc_d  = ZERO_WORD;
`endif
    end else if (!stall_if) begin
      pc_d   = if_pc;
      inst_d = if_inst;
`ifdef IF_ADEL_CHECK_EN
      exc_d  = if_excepttype;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= ZERO_WORD;
      inst_q <= ZERO_WORD;
`ifdef IF_ADEL_CHECK_EN
      exc_q  <= ZERO_WORD;
`endif
    end else begin
      pc_q   <= pc_d;
      inst_q <= inst_d;
`ifdef IF_ADEL_CHECK_EN
      exc_q  <= exc_d;
`endif
    end
  end

  assign id_pc_o   = pc_q;
  assign id_inst_o = inst_q;
`ifdef IF_ADEL_CHECK_EN
  assign id_excepttype_o = exc_q;
`endif

endmodule : if_fetch_stage_if_id_reg
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : Instruction-fetch front end of the 5-stage MIPS32 core. Owns
//               the PC and a two-state IDLE/RUN FSM, drives the ROM chip
//               enable and byte address, and feeds the IF/ID register.
//               PC priority in RUN: flush > stall[0] > branch > PC+PC_STEP.
// Optional    : IF_ADEL_CHECK_EN - misaligned PC disables the ROM, loads a
//               NOP and flags AdEL on id_excepttype_o.
// Ports       : clk, rst (async active-low), stall[5:0], flush, new_pc,
//               branch_flag_i, branch_target_address_i, rom_inst_i,
//               rom_ce_o, rom_addr_o, id_pc_o, id_inst_o,
//               id_excepttype_o (feature only).
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             stall,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] new_pc,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_address_i,
  input  logic [INST_W-1:0]      rom_inst_i,
  output logic                   rom_ce_o,
  output logic [INST_ADDR_W-1:0] rom_addr_o,
  output logic [INST_ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0]      id_inst_o
`ifdef IF_ADEL_CHECK_EN
  ,
  output logic [31:0]            id_excepttype_o
`endif
);

  localparam logic [INST_ADDR_W-1:0] C_PC_INC = INST_ADDR_W'(PC_STEP);

  fetch_state_e           state_q, state_d;
  logic [INST_ADDR_W-1:0] pc_q,    pc_d;

  logic                   w_run;
  logic [INST_ADDR_W-1:0] w_fetch_pc;
  logic [INST_W-1:0]      w_fetch_inst;

  // Later-stage stall bits are not consumed by the fetch stage
  logic                   unused_stall;
  assign unused_stall = ^stall[5:3];

  // --------------------------------------------------------------------------
  // FSM and PC
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE: begin
        // One idle cycle after reset release, then fetching starts at RESET_PC
        state_d = S_RUN;
        pc_d    = RESET_PC;
      end
      S_RUN: begin
        state_d = S_RUN;
        if (flush) begin
          pc_d = new_pc;
        end else if (stall[STALL_PC]) begin
          pc_d = pc_q;
        end else if (branch_flag_i) begin
          pc_d = branch_target_address_i;
        end else begin
          pc_d = pc_q + C_PC_INC;   // natural modulo-2^32 wrap
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = RESET_PC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign w_run      = (state_q == S_RUN);
  assign rom_addr_o = pc_q;

  // --------------------------------------------------------------------------
  // ROM enable and fetch data (zeroed whenever the ROM is disabled so the
  // IF/ID register can never pick up stale data)
  // --------------------------------------------------------------------------
`ifdef IF_ADEL_CHECK_EN
  logic        w_adel;
  logic [31:0] w_fetch_exc;

  assign w_adel      = w_run && (pc_q[1:0] != 2'b00);
  assign rom_ce_o    = w_run && !w_adel;
  assign w_fetch_exc = w_adel ? (32'h1 << EXC_ADEL_BIT) : ZERO_WORD;
`else
  assign rom_ce_o    = w_run ? ENABLE : DISABLE;
`endif

  assign w_fetch_pc   = rom_ce_o ? pc_q       : ZERO_WORD;
  assign w_fetch_inst = rom_ce_o ? rom_inst_i : ZERO_WORD;

  // --------------------------------------------------------------------------
  // IF/ID pipeline register
  // --------------------------------------------------------------------------
  if_fetch_stage_if_id_reg u_if_id_reg (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .stall_if        (stall[STALL_IF]),
    .stall_id        (stall[STALL_ID]),
    .if_pc           (w_fetch_pc),
    .if_inst         (w_fetch_inst),
`ifdef IF_ADEL_CHECK_EN
    .if_excepttype   (w_fetch_exc),
    .id_excepttype_o (id_excepttype_o),
`endif
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o)
  );

endmodule : if_fetch_stage
`default_nettype wire
